// File: rtl/write_unshifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_unshifter_pkg
// Description : Shared constants and helpers for the write-path lane unshifter.
// Revision    : 1.0 - initial release
// ============================================================================
package write_unshifter_pkg;

    localparam int MAX_LANES = 64;

    localparam logic [0:0] C_ST_ACCUM = 1'b0;
    localparam logic [0:0] C_ST_FLUSH = 1'b1;

    function automatic int c_log_2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Lane j is set when it is one of the `count` lanes starting at `ptr`, modulo n.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int ptr, input int count, input int n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int j = 0; j < MAX_LANES; j++) begin
            if (j < n && (((j - ptr) & (n - 1)) < count)) m[j] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_unshifter_lane_rotl.sv
`default_nettype none
// ============================================================================
// Module      : lane_rotl
// Description : Combinational left lane-rotate; input lane k lands on lane
//               (k + i_ctrl) mod NUM_DATA. Inverse of the read-path rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_rotl
    import write_unshifter_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_DATA   = 16,
    localparam int LINE_WIDTH = DATA_WIDTH * NUM_DATA,
    localparam int CTRL_WIDTH = c_log_2(NUM_DATA)
) (
    input  logic [LINE_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    output logic [LINE_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_lane [NUM_DATA];

    for (genvar j = 0; j < NUM_DATA; j++) begin : g_lane
        logic [CTRL_WIDTH-1:0] w_src;
        assign w_lane[j] = i_data[j*DATA_WIDTH +: DATA_WIDTH];
        assign w_src     = CTRL_WIDTH'(j) - i_ctrl;
        assign o_data[j*DATA_WIDTH +: DATA_WIDTH] = w_lane[w_src];
    end

endmodule
`default_nettype wire

// File: rtl/write_unshifter.sv
`default_nettype none
// ============================================================================
// Module      : write_unshifter
// Description : Packs variable-count beats into memory lines with lane strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module write_unshifter
    import write_unshifter_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_DATA   = 16,
    localparam int LINE_WIDTH = DATA_WIDTH * NUM_DATA,
    localparam int CTRL_WIDTH = c_log_2(NUM_DATA)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [LINE_WIDTH-1:0] S_DATA,
    input  logic [CTRL_WIDTH:0]   S_COUNT,
    input  logic                  S_LAST,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [LINE_WIDTH-1:0] M_DATA,
    output logic [NUM_DATA-1:0]   M_STRB,
    output logic                  M_LAST
);

    localparam logic [CTRL_WIDTH:0] C_NUM = (CTRL_WIDTH+1)'(NUM_DATA);

    logic [0:0]            r_state;
    logic [CTRL_WIDTH-1:0] r_ptr;
    logic [LINE_WIDTH-1:0] r_acc;
    logic [NUM_DATA-1:0]   r_acc_strb;
    logic                  r_m_valid;
    logic [LINE_WIDTH-1:0] r_m_data;
    logic [NUM_DATA-1:0]   r_m_strb;
    logic                  r_m_last;

    logic                  w_out_free;
    logic                  w_accept;
    logic [CTRL_WIDTH:0]   w_count;
    logic [CTRL_WIDTH:0]   w_sum;
    logic [LINE_WIDTH-1:0] w_rot;
    logic [NUM_DATA-1:0]   w_mask;
    logic [NUM_DATA-1:0]   w_below_ptr;
    logic [NUM_DATA-1:0]   w_wrap;
    logic [NUM_DATA-1:0]   w_nowrap;
    logic [LINE_WIDTH-1:0] w_merged;
    logic [NUM_DATA-1:0]   w_merged_strb;
    logic [LINE_WIDTH-1:0] w_wrap_data;

    logic [0:0]            w_state_nxt;
    logic [CTRL_WIDTH-1:0] w_ptr_nxt;
    logic [LINE_WIDTH-1:0] w_acc_nxt;
    logic [NUM_DATA-1:0]   w_acc_strb_nxt;
    logic                  w_load;
    logic [LINE_WIDTH-1:0] w_ld_data;
    logic [NUM_DATA-1:0]   w_ld_strb;
    logic                  w_ld_last;

    assign w_out_free = !r_m_valid || M_READY;
    assign S_READY    = (r_state == C_ST_ACCUM) && w_out_free && !ARESET;
    assign w_accept   = S_VALID && S_READY;

    // Out-of-range counts are clamped so the hardware never corrupts neighbouring lanes.
    assign w_count     = (S_COUNT > C_NUM) ? C_NUM : S_COUNT;
    assign w_sum       = {1'b0, r_ptr} + w_count;
    assign w_mask      = NUM_DATA'(lane_mask(int'(r_ptr), int'(w_count), NUM_DATA));
    assign w_below_ptr = NUM_DATA'(lane_mask(0, int'(r_ptr), NUM_DATA));
    assign w_wrap      = w_mask & w_below_ptr;
    assign w_nowrap    = w_mask & ~w_below_ptr;

    lane_rotl #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DATA   (NUM_DATA)
    ) u_rotl (
        .i_data (S_DATA),
        .i_ctrl (r_ptr),
        .o_data (w_rot)
    );

    always_comb begin
        w_merged      = r_acc;
        w_wrap_data   = '0;
        w_merged_strb = r_acc_strb | w_nowrap;
        for (int j = 0; j < NUM_DATA; j++) begin
            if (w_nowrap[j]) w_merged[j*DATA_WIDTH +: DATA_WIDTH] = w_rot[j*DATA_WIDTH +: DATA_WIDTH];
            if (w_wrap[j])   w_wrap_data[j*DATA_WIDTH +: DATA_WIDTH] = w_rot[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_acc_nxt      = r_acc;
        w_acc_strb_nxt = r_acc_strb;
        w_load         = 1'b0;
        w_ld_data      = w_merged;
        w_ld_strb      = w_merged_strb;
        w_ld_last      = 1'b0;
        if (r_state == C_ST_FLUSH) begin
            if (w_out_free) begin
                w_load         = 1'b1;
                w_ld_data      = r_acc;
                w_ld_strb      = r_acc_strb;
                w_ld_last      = 1'b1;
                w_ptr_nxt      = '0;
                w_acc_nxt      = '0;
                w_acc_strb_nxt = '0;
                w_state_nxt    = C_ST_ACCUM;
            end
        end else if (w_accept) begin
            if (S_LAST) begin
                w_load = 1'b1;
                w_ptr_nxt = '0;
                if (w_sum > C_NUM) begin
                    w_acc_nxt      = w_wrap_data;
                    w_acc_strb_nxt = w_wrap;
                    w_state_nxt    = C_ST_FLUSH;
                end else begin
                    w_ld_last      = 1'b1;
                    w_acc_nxt      = '0;
                    w_acc_strb_nxt = '0;
                end
            end else if (w_sum >= C_NUM) begin
                // NUM_DATA is a power of two, so dropping the MSB subtracts NUM_DATA.
                w_load         = 1'b1;
                w_acc_nxt      = w_wrap_data;
                w_acc_strb_nxt = w_wrap;
                w_ptr_nxt      = w_sum[CTRL_WIDTH-1:0];
            end else begin
                w_acc_nxt      = w_merged;
                w_acc_strb_nxt = w_merged_strb;
                w_ptr_nxt      = w_sum[CTRL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= C_ST_ACCUM;
            r_ptr      <= '0;
            r_acc      <= '0;
            r_acc_strb <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_strb   <= '0;
            r_m_last   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_acc      <= w_acc_nxt;
            r_acc_strb <= w_acc_strb_nxt;
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_ld_data;
                r_m_strb  <= w_ld_strb;
                r_m_last  <= w_ld_last;
            end else if (M_READY) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign M_VALID = r_m_valid;
    assign M_DATA  = r_m_data;
    assign M_STRB  = r_m_strb;
    assign M_LAST  = r_m_last;

    a_count_legal: assert property (@(posedge ACLK) disable iff (ARESET)
        S_VALID |-> (S_COUNT <= C_NUM));

endmodule
`default_nettype wire
